// File: rtl/uart_fp_tx.sv
// uart_fp_tx: 8N1 UART transmitter sending one field element LSB byte first, then pulsing done
module uart_fp_tx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 460800,
  parameter int DATA_W       = 289,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int NBYTES       = (DATA_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);
  localparam int SW = NBYTES * 8;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int YW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [YW-1:0] LAST_BYTE = YW'(NBYTES - 1);
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [YW-1:0] byte_cnt, byte_n;
  logic [SW-1:0] sreg, sreg_n;
  logic txd_n, done_n, tick;
  assign tick = baud_cnt == LAST_TICK;
  assign din_ready = state == IDLE;
  assign busy = state != IDLE;
  // next-state logic; txd and done are computed from the next state so both outputs come straight from flops
  always_comb begin
    state_n = state;
    baud_n = baud_cnt + BW'(1);
    bit_n = bit_cnt;
    byte_n = byte_cnt;
    sreg_n = sreg;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (din_valid) begin
          sreg_n = SW'(din);
          byte_n = '0;
          state_n = START;
        end
      end
      START: if (tick) begin
        baud_n = '0;
        bit_n = '0;
        state_n = DATA;
      end
      DATA: if (tick) begin
        baud_n = '0;
        bit_n = bit_cnt + 3'd1;
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        baud_n = '0;
        if (byte_cnt == LAST_BYTE) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          byte_n = byte_cnt + YW'(1);
          sreg_n = sreg >> 8;
          state_n = START;
        end
      end
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? sreg_n[bit_n] : 1'b1;
  end
  // state, counters, payload and registered line outputs; reset drops any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      sreg <= '0;
      txd <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      byte_cnt <= byte_n;
      sreg <= sreg_n;
      txd <= txd_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_fp_tx.sv
// tb_uart_fp_tx: random elements through the transmitter, decoded by a host-side UART monitor against a byte/timing scoreboard
module tb_uart_fp_tx;
  localparam int CPB = 8, DW = 289, NB = 37, FRAME = 10 * CPB, ELEM = NB * FRAME;
  typedef struct {logic [7:0] b; int t;} frame_t;
  logic clk = 0, rst = 0, din_valid = 0, din_ready, txd, busy, done;
  logic [DW-1:0] din = '0;
  frame_t exp_q[$];
  int done_q[$];
  int cyc = 0, acc = 0, done_c = 0, errors = 0, checks = 0;
  int t0;
  logic [9:0] lv;
  bit gl, ab;
  frame_t f;
  logic [DW-1:0] a, b;

  uart_fp_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  task automatic expect_elem(input logic [DW-1:0] d, input int at);
    logic [NB*8-1:0] e;
    frame_t fr;
    e = '0;
    e[DW-1:0] = d;
    for (int i = 0; i < NB; i++) begin
      fr.b = e[8*i +: 8];
      fr.t = at + i * FRAME;
      exp_q.push_back(fr);
    end
    done_q.push_back(at + ELEM);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit keep);
    int n = 0;
    din = d;
    din_valid = 1'b1;
    while (!din_ready && n <= ELEM + 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      chk("accept_wait", din_ready, 1);
      din_valid = 1'b0;
      return;
    end
    #1;
    acc = cyc + 1;
    done_c = acc + ELEM;
    expect_elem(d, acc);
    @(negedge clk);
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && n < 2 * ELEM) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", done_q.size(), 0);
    chk("drain_bytes", exp_q.size(), 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // handshake/busy window and done timing against the expected element window
  always @(negedge clk) begin
    chk("busy", busy, cyc >= acc && cyc < done_c);
    chk("din_ready", din_ready, !(cyc >= acc && cyc < done_c));
    if (done === 1'b1) begin
      if (done_q.size() == 0) fail("done_spurious", "got done=1 required no done pulse");
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  // host-side UART receiver: samples every cycle of each frame
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        t0 = cyc;
        gl = 0;
        ab = 0;
        lv = '0;
        for (int k = 0; k < 10 && !ab; k++)
          for (int c = 0; c < CPB && !ab; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rst) ab = 1;
            if (c == 0) lv[k] = txd;
            else if (txd !== lv[k]) gl = 1;
          end
        if (!ab) begin
          if (exp_q.size() == 0) fail("unexpected_frame", $sformatf("got byte %0h required no frame", lv[8:1]));
          else begin
            f = exp_q.pop_front();
            chk("start_bit", lv[0], 0);
            chk("stop_bit", lv[9], 1);
            chk("bit_stable", gl, 0);
            chk("frame_time", t0, f.t);
            chk("byte", lv[8:1], f.b);
          end
        end
      end
    end
  end

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #2 rst = 0;
    @(negedge clk);
    send(DW'(1), 0);
    wait_idle();
    a = '0;
    a[DW-1] = 1'b1;
    a[7:0] = 8'hA5;
    send(a, 0);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      send(rnd(), 0);
      wait_idle();
    end
    a = rnd();
    b = rnd();
    send(a, 1);
    send(b, 0);
    wait_idle();
    send(rnd(), 0);
    while (cyc < acc + ELEM - 20) begin
      @(negedge clk);
      din_valid = 1'($urandom_range(0, 1));
      din = rnd();
    end
    din_valid = 1'b0;
    wait_idle();
    send(rnd(), 0);
    while (cyc < acc + 5 * FRAME + 4 * CPB) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_txd", txd, 1);
    chk("async_busy", busy, 0);
    chk("async_din_ready", din_ready, 1);
    chk("async_done", done, 0);
    acc = 0;
    done_c = 0;
    exp_q.delete();
    done_q.delete();
    repeat (4) @(negedge clk);
    din = rnd();
    din_valid = 1'b1;
    #2 rst = 0;
    send(rnd(), 0);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
